data_sram_confreg: RTL and testbench
====================================

Name: data_sram_confreg

Overview:
Responder end of the CPU data-SRAM interface. Serves the single-cycle core's load and store traffic from an internal word RAM. Also decodes a memory-mapped I/O window holding LED, switch, seven-segment number, a free-running timer with compare, and a sticky timer-hit status. Sits between the core's data_sram_* port and board-level I/O.

Parameters:
RAM_AW, 10, RAM word-address width; RAM depth is 2**RAM_AW 32-bit words.
MMIO_BASE_HI, 16'hBFAF, value of addr[31:16] that selects the MMIO window.

Ports:
clk  input  1  system clock; all state updates on rising edge
resetn  input  1  asynchronous active-low reset
data_sram_we  input  1  word write strobe from core
data_sram_addr  input  32  byte address from core; addr[1:0] ignored
data_sram_wdata  input  32  store data from core
data_sram_rdata  output  32  read data to core, combinational from addr
switch  input  16  board switches, asynchronous to clk
led  output  16  LED register
num  output  32  seven-segment number register
timer_irq  output  1  equals STATUS bit0

Behaviour:
- Reset (resetn low, asynchronous): LED, NUM, TIMER, CMP, STATUS and both switch-sync flops clear to 0 immediately. led=0, num=0, timer_irq=0.
- Reset does not clear RAM contents. While resetn is low, no writes occur (RAM or MMIO).
- Decode:
  - mmio_sel = (addr[31:16] == MMIO_BASE_HI).
  - Otherwise the access targets RAM word addr[RAM_AW+1:2]; upper address bits are aliased (ignored).
- Read timing: zero latency. data_sram_rdata is a pure combinational function of the current addr and the current register/RAM state. It is valid in the same cycle, as the single-cycle core requires. A read in the same cycle as a write to that address returns the OLD value.
- Write timing: commits at the rising edge where data_sram_we=1. The new value is visible to reads from the next cycle.
- MMIO map (offset = addr[15:0]):
  - 0xF000 LED: RW, bits[15:0]; read zero-extends.
  - 0xF004 SWITCH: RO, bits[15:0]; value of the second sync flop; writes ignored.
  - 0xF008 TIMER: RW, 32b.
  - 0xF00C NUM: RW, 32b.
  - 0xF010 CMP: RW, 32b.
  - 0xF014 STATUS: bit0 = hit; write-1-to-clear; write 0 has no effect; bits[31:1] read 0.
  - Any other offset in the window: reads 0, writes ignored.
- Switch sync: two-flop synchronizer. A switch change is readable at SWITCH on the 2nd rising edge after it becomes stable.
- TIMER:
  - Increments by 1 every cycle out of reset; wraps 0xFFFFFFFF -> 0x00000000.
  - A write to TIMER has priority over increment: the loaded value is visible the next cycle and increments after that.
- Hit detect: STATUS.hit sets on the edge following any cycle where TIMER == CMP and CMP != 0. CMP == 0 disables the compare.
  - Simultaneous set condition and W1C in the same cycle: set wins, hit stays 1.
  - A hit that is already set stays set until cleared.
- timer_irq = STATUS.hit (registered, no combinational path from the bus).
- Writing TIMER or CMP does not modify STATUS.

Test Plan:
1. Reset, then write RAM 0x1C000010 <= 0x12345678 and read 0x1C000010 next cycle -> rdata=0x12345678. Read 0x1C000010+(4<<RAM_AW) -> same value (aliasing).
2. Same-cycle read/write: addr 0x1C000020 holds 0xAAAA0000; drive we=1, wdata=0x5555FFFF -> rdata=0xAAAA0000 that cycle, 0x5555FFFF next cycle.
3. Write 0xBFAFF000 <= 0xFFFF1234 -> led=0x1234 next cycle, read returns 0x00001234. Write 0xBFAFF00C <= 0xDEADBEEF -> num=0xDEADBEEF. Write and read 0xBFAFF020 -> reads 0, no output change.
4. switch=16'hA5C3 (from 0) -> SWITCH reads 0 after 1 edge, 0xA5C3 after 2 edges. Write to 0xBFAFF004 does not change it.
5. Timer/compare:
   - Write TIMER=0xFFFFFFFE and CMP=0x00000003.
   - Expected TIMER sequence: FFFFFFFE, FFFFFFFF, 0, 1, 2, 3.
   - timer_irq rises the edge after TIMER==3.
   - W1C 0xBFAFF014 <= 1 -> timer_irq=0 next cycle.
   - W1C issued in the cycle TIMER==CMP -> timer_irq stays 1.
6. Assert resetn low mid-run with led=0x00FF, TIMER=0x100, hit=1 -> led, num, timer_irq drop to 0 without a clock edge. Release -> TIMER counts from 0. RAM word written before reset still reads back intact.

Source files
------------

// File: rtl/data_sram_confreg.sv
// Data-SRAM responder: word RAM plus an MMIO window (LED, SWITCH, TIMER, NUM, CMP, STATUS).
// Reads are combinational (zero latency); writes commit at the clock edge; no backpressure.
module data_sram_confreg #(
  parameter int          RAM_AW       = 10,
  parameter logic [15:0] MMIO_BASE_HI = 16'hBFAF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_sram_we,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  input  logic [15:0] switch,
  output logic [15:0] led,
  output logic [31:0] num,
  output logic        timer_irq
);

  localparam logic [15:0] OFF_LED    = 16'hF000;
  localparam logic [15:0] OFF_SWITCH = 16'hF004;
  localparam logic [15:0] OFF_TIMER  = 16'hF008;
  localparam logic [15:0] OFF_NUM    = 16'hF00C;
  localparam logic [15:0] OFF_CMP    = 16'hF010;
  localparam logic [15:0] OFF_STATUS = 16'hF014;

  logic [31:0]       ram [2**RAM_AW];
  logic [RAM_AW-1:0] ram_idx;
  logic [15:0]       offset;
  logic              mmio_sel;
  logic              ram_we;

  logic [15:0] led_q;
  logic [31:0] num_q;
  logic [31:0] timer_q;
  logic [31:0] cmp_q;
  logic        hit_q;
  logic [15:0] sw_meta;
  logic [15:0] sw_sync;

  logic wr_mmio;
  logic wr_led;
  logic wr_timer;
  logic wr_num;
  logic wr_cmp;
  logic wr_status;
  logic hit_set;
  logic hit_clr;
  logic unused_addr_lsb;

  assign mmio_sel        = (data_sram_addr[31:16] == MMIO_BASE_HI);
  assign offset          = data_sram_addr[15:0];
  assign ram_idx         = data_sram_addr[RAM_AW+1:2];
  assign unused_addr_lsb = ^data_sram_addr[1:0];

  // resetn folded into the enable so the RAM never sees a write while held in reset
  assign ram_we    = data_sram_we & ~mmio_sel & resetn;
  assign wr_mmio   = data_sram_we & mmio_sel;
  assign wr_led    = wr_mmio & (offset == OFF_LED);
  assign wr_timer  = wr_mmio & (offset == OFF_TIMER);
  assign wr_num    = wr_mmio & (offset == OFF_NUM);
  assign wr_cmp    = wr_mmio & (offset == OFF_CMP);
  assign wr_status = wr_mmio & (offset == OFF_STATUS);

  assign hit_set = (timer_q == cmp_q) && (cmp_q != 32'd0);
  assign hit_clr = wr_status & data_sram_wdata[0];

  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram[ram_idx] <= data_sram_wdata;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sw_meta <= 16'd0;
      sw_sync <= 16'd0;
    end else begin
      sw_meta <= switch;
      sw_sync <= sw_meta;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      led_q <= 16'd0;
      num_q <= 32'd0;
      cmp_q <= 32'd0;
    end else begin
      if (wr_led) led_q <= data_sram_wdata[15:0];
      if (wr_num) num_q <= data_sram_wdata;
      if (wr_cmp) cmp_q <= data_sram_wdata;
    end
  end

  // A bus load of TIMER takes precedence over the free-running increment
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      timer_q <= 32'd0;
    end else if (wr_timer) begin
      timer_q <= data_sram_wdata;
    end else begin
      timer_q <= timer_q + 32'd1;
    end
  end

  // Set beats clear when a match and a W1C land in the same cycle
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hit_q <= 1'b0;
    end else begin
      hit_q <= hit_set | (hit_q & ~hit_clr);
    end
  end

  always_comb begin
    data_sram_rdata = 32'd0;
    if (mmio_sel) begin
      case (offset)
        OFF_LED:    data_sram_rdata = {16'd0, led_q};
        OFF_SWITCH: data_sram_rdata = {16'd0, sw_sync};
        OFF_TIMER:  data_sram_rdata = timer_q;
        OFF_NUM:    data_sram_rdata = num_q;
        OFF_CMP:    data_sram_rdata = cmp_q;
        OFF_STATUS: data_sram_rdata = {31'd0, hit_q};
        default:    data_sram_rdata = 32'd0;
      endcase
    end else begin
      data_sram_rdata = ram[ram_idx];
    end
  end

  assign led       = led_q;
  assign num       = num_q;
  assign timer_irq = hit_q;

endmodule

// File: tb/tb_data_sram_confreg.sv
// Randomized scoreboard bench for data_sram_confreg against a register-level reference model.
module tb_data_sram_confreg;

  localparam int RAM_AW = 10;

  logic        clk = 1'b0;
  logic        resetn;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [15:0] sw;
  logic [15:0] led;
  logic [31:0] num;
  logic        irq;

  always #5 clk = ~clk;

  data_sram_confreg #(.RAM_AW(RAM_AW), .MMIO_BASE_HI(16'hBFAF)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .data_sram_we    (we),
    .data_sram_addr  (addr),
    .data_sram_wdata (wdata),
    .data_sram_rdata (rdata),
    .switch          (sw),
    .led             (led),
    .num             (num),
    .timer_irq       (irq)
  );

  typedef struct {
    logic [31:0] rdata;
    logic [15:0] led;
    logic [31:0] num;
    logic        irq;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model state
  logic [31:0] mem_m [int];
  logic [15:0] led_m;
  logic [31:0] num_m, timer_m, cmp_m;
  logic        hit_m;
  logic [15:0] sw_d1_m, sw_d2_m;

  function automatic void model_reset();
    led_m = 0; num_m = 0; timer_m = 0; cmp_m = 0; hit_m = 0;
    sw_d1_m = 0; sw_d2_m = 0;
  endfunction

  function automatic logic [31:0] model_read(logic [31:0] a);
    int idx;
    if (a[31:16] == 16'hBFAF) begin
      case (a[15:0])
        16'hF000: return {16'd0, led_m};
        16'hF004: return {16'd0, sw_d2_m};
        16'hF008: return timer_m;
        16'hF00C: return num_m;
        16'hF010: return cmp_m;
        16'hF014: return {31'd0, hit_m};
        default:  return 32'd0;
      endcase
    end
    idx = int'(a[RAM_AW+1:2]);
    return mem_m.exists(idx) ? mem_m[idx] : 32'd0;
  endfunction

  // State change at a rising edge, from the values on the bus during the cycle
  task automatic model_edge();
    logic        mmio, set_c, clr_c;
    logic [31:0] t_next;
    if (!resetn) return;
    mmio   = (addr[31:16] == 16'hBFAF);
    set_c  = (timer_m == cmp_m) && (cmp_m != 0);
    clr_c  = we && mmio && (addr[15:0] == 16'hF014) && wdata[0];
    t_next = timer_m + 32'd1;
    if (we && mmio) begin
      case (addr[15:0])
        16'hF000: led_m  = wdata[15:0];
        16'hF008: t_next = wdata;
        16'hF00C: num_m  = wdata;
        16'hF010: cmp_m  = wdata;
        default: ;
      endcase
    end else if (we) begin
      mem_m[int'(addr[RAM_AW+1:2])] = wdata;
    end
    hit_m   = set_c || (hit_m && !clr_c);
    timer_m = t_next;
    sw_d2_m = sw_d1_m;
    sw_d1_m = sw;
  endtask

  // Drive one bus cycle (entered at posedge+1) and queue what the DUT must show during it
  task automatic cycle(input logic w, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    we = w; addr = a; wdata = d;
    e.rdata = model_read(a);
    e.led   = led_m;
    e.num   = num_m;
    e.irq   = hit_m;
    q.push_back(e);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h, expected %h (addr %h)", nm, $time, act, exp, addr);
    end
  endfunction

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("rdata", rdata, e.rdata);
      chk("led", {16'd0, led}, {16'd0, e.led});
      chk("num", num, e.num);
      chk("timer_irq", {31'd0, irq}, {31'd0, e.irq});
    end
  end

  function automatic logic [31:0] ram_addr(int idx);
    logic [31:0] a;
    a = $urandom;
    a[RAM_AW+1:2] = idx[RAM_AW-1:0];
    if (a[31:16] == 16'hBFAF) a[31] = 1'b0;
    return a;
  endfunction

  // Load TIMER two below CMP so the W1C lands in the cycle TIMER == CMP
  task automatic w1c_at_match();
    cycle(1'b1, 32'hBFAFF008, cmp_m - 32'd2);
    cycle(1'b0, 32'hBFAFF008, 32'd0);
    cycle(1'b0, 32'hBFAFF008, 32'd0);
    cycle(1'b1, 32'hBFAFF014, 32'd1);
    cycle(1'b0, 32'hBFAFF014, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    resetn = 1'b0; we = 1'b0; addr = 32'hBFAFF000; wdata = 32'd0; sw = 16'd0;
    model_reset();
    @(posedge clk); #1;
    cycle(1'b0, 32'hBFAFF008, 32'd0);
    cycle(1'b0, 32'hBFAFF014, 32'd0);
    resetn = 1'b1;
    cycle(1'b0, 32'hBFAFF008, 32'd0);
    cycle(1'b0, 32'hBFAFF008, 32'd0);

    for (int i = 0; i < 16; i++) cycle(1'b1, 32'h1C000000 + 32'(i * 4), $urandom);

    // RAM write/read and upper-address aliasing
    cycle(1'b1, 32'h1C000010, 32'h12345678);
    cycle(1'b0, 32'h1C000010, 32'd0);
    cycle(1'b0, 32'h1C000010 + (32'd4 << RAM_AW), 32'd0);
    // Read-during-write returns the old word
    cycle(1'b1, 32'h1C000020, 32'hAAAA0000);
    cycle(1'b1, 32'h1C000020, 32'h5555FFFF);
    cycle(1'b0, 32'h1C000020, 32'd0);
    // LED / NUM / unmapped offset
    cycle(1'b1, 32'hBFAFF000, 32'hFFFF1234);
    cycle(1'b0, 32'hBFAFF000, 32'd0);
    cycle(1'b1, 32'hBFAFF00C, 32'hDEADBEEF);
    cycle(1'b0, 32'hBFAFF00C, 32'd0);
    cycle(1'b1, 32'hBFAFF020, 32'hFFFFFFFF);
    cycle(1'b0, 32'hBFAFF020, 32'd0);
    // Switch synchronizer depth, read-only
    cycle(1'b0, 32'hBFAFF004, 32'd0);
    sw = 16'hA5C3;
    for (int i = 0; i < 3; i++) cycle(1'b0, 32'hBFAFF004, 32'd0);
    cycle(1'b1, 32'hBFAFF004, 32'h00001111);
    cycle(1'b0, 32'hBFAFF004, 32'd0);
    // Timer wrap and compare hit
    cycle(1'b1, 32'hBFAFF010, 32'h00000003);
    cycle(1'b1, 32'hBFAFF008, 32'hFFFFFFFE);
    for (int i = 0; i < 8; i++) cycle(1'b0, 32'hBFAFF008, 32'd0);
    cycle(1'b0, 32'hBFAFF014, 32'd0);
    cycle(1'b1, 32'hBFAFF014, 32'h00000001);
    cycle(1'b0, 32'hBFAFF014, 32'd0);
    cycle(1'b1, 32'hBFAFF014, 32'h00000000);
    // W1C colliding with a match: set must win
    cycle(1'b1, 32'hBFAFF010, 32'h00000040);
    w1c_at_match();
    w1c_at_match();
    cycle(1'b0, 32'hBFAFF010, 32'd0);

    // Asynchronous reset mid-run; RAM survives, writes during reset are dropped
    cycle(1'b1, 32'hBFAFF000, 32'h000000FF);
    cycle(1'b1, 32'hBFAFF008, 32'h00000100);
    cycle(1'b1, 32'h1C000040, 32'hCAFEF00D);
    resetn = 1'b0;
    model_reset();
    cycle(1'b1, 32'h1C000040, 32'h0BADBAD0);
    cycle(1'b1, 32'hBFAFF000, 32'h0000BEEF);
    cycle(1'b0, 32'hBFAFF008, 32'd0);
    resetn = 1'b1;
    cycle(1'b0, 32'hBFAFF008, 32'd0);
    cycle(1'b0, 32'hBFAFF008, 32'd0);
    cycle(1'b0, 32'h1C000040, 32'd0);
    cycle(1'b0, 32'hBFAFF004, 32'd0);

    // Randomized traffic over a 16-word RAM pool and the whole MMIO window
    for (int n = 0; n < 1500; n++) begin
      int          r;
      logic [31:0] a, d;
      r = int'($urandom_range(0, 9));
      if ($urandom_range(0, 15) == 0) sw = 16'($urandom);
      if (r < 4) begin
        a = ram_addr(int'($urandom_range(0, 15)));
        cycle(1'($urandom_range(0, 1)), a, $urandom);
      end else begin
        a = 32'hBFAFF000 + 32'(4 * $urandom_range(0, 7));
        d = $urandom;
        if (a[15:0] == 16'hF010 && $urandom_range(0, 1) == 1) d = timer_m + 32'($urandom_range(1, 6));
        if (a[15:0] == 16'hF008 && $urandom_range(0, 1) == 1) d = cmp_m - 32'($urandom_range(1, 4));
        cycle(1'($urandom_range(0, 2) == 0), a, d);
      end
    end

    we = 1'b0;
    @(negedge clk); #1;
    n_vec++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
